// File: rtl/tx_block_sched.sv
// rtl/tx_block_sched.sv - PIPE transmit block scheduler: OS/data arbitration, 128b/130b framing, gearbox stall
module tx_block_sched #(
    parameter int DW      = 32,
    parameter bit OS_PRIO = 1'b1
) (
    input  logic            pclk,
    input  logic            reset_n,
    input  logic [2:0]      GEN,
    input  logic [5:0]      PIPEWIDTH,
    input  logic            os_req,
    input  logic [1:0]      os_type,
    input  logic [DW-1:0]   os_data,
    input  logic [DW/8-1:0] os_k,
    input  logic            os_last,
    output logic            os_ack,
    input  logic            dl_valid,
    input  logic [DW-1:0]   dl_data,
    output logic            dl_ready,
    output logic [DW-1:0]   tx_data,
    output logic [DW/8-1:0] tx_k,
    output logic            tx_data_valid,
    output logic [1:0]      tx_sync_header,
    output logic            tx_start_block,
    output logic            tx_turn_off,
    output logic            pattern_reset,
    output logic            frame_err
);
    typedef enum logic [1:0] {IDLE, BLK_DATA, BLK_OS, STALL} state_t;

    state_t          state, state_n;
    logic [3:0]      wcnt, wcnt_n, bcnt, bcnt_n, cpb_last, blk_last;
    logic [2:0]      gen_cur, gen_eff;
    logic [1:0]      cur_type, cur_type_n, typ_now;
    logic            os_done, os_done_n, os_done_eff;
    logic            gen_chg, grant_os, arb, is_os, adv, last, ack, rdy;
    logic [DW-1:0]   data_n;
    logic [DW/8-1:0] k_n;
    logic [1:0]      sync_n;
    logic            valid_n, start_n, turn_off_n, prst_n, ferr_n;

    always_comb begin
        case (PIPEWIDTH)
            6'd8:    begin cpb_last = 4'd15; blk_last = 4'd3;  end
            6'd16:   begin cpb_last = 4'd7;  blk_last = 4'd7;  end
            default: begin cpb_last = 4'd3;  blk_last = 4'd15; end
        endcase
    end

    // IDLE follows GEN directly; elsewhere a GEN change waits for a clean boundary
    assign gen_eff  = (state == IDLE) ? GEN : gen_cur;
    assign gen_chg  = (state != IDLE) && (GEN != gen_cur);
    assign grant_os = os_req && (OS_PRIO || !dl_valid);
    assign last     = (wcnt == cpb_last);

    always_comb begin
        state_n     = state;
        wcnt_n      = wcnt;
        bcnt_n      = bcnt;
        cur_type_n  = cur_type;
        os_done_n   = os_done;
        os_done_eff = 1'b0;
        typ_now     = cur_type;
        arb         = 1'b0;
        is_os       = 1'b0;
        adv         = 1'b0;
        ack         = 1'b0;
        rdy         = 1'b0;
        data_n      = '0;
        k_n         = '0;
        valid_n     = 1'b1;
        sync_n      = 2'b00;
        start_n     = 1'b0;
        turn_off_n  = 1'b0;
        prst_n      = 1'b0;
        ferr_n      = frame_err;
        if (gen_eff >= 3'd3) begin
            if (state == STALL) begin
                valid_n = 1'b0;
                state_n = BLK_DATA;
            end else begin
                arb         = (wcnt == 4'd0);
                is_os       = arb ? grant_os : (state == BLK_OS);
                typ_now     = arb ? os_type : cur_type;
                os_done_eff = arb ? 1'b0 : os_done;
                cur_type_n  = typ_now;
                sync_n      = is_os ? 2'b10 : 2'b01;
                start_n     = arb;
                if (is_os) begin
                    // after an early os_last the block is padded out with IDL
                    if (!os_done_eff && os_req) begin
                        ack    = 1'b1;
                        data_n = os_data;
                        adv    = 1'b1;
                    end else if (os_done_eff) begin
                        adv = 1'b1;
                    end
                end else begin
                    rdy    = dl_valid;
                    data_n = dl_valid ? dl_data : '0;
                    adv    = 1'b1;
                end
                if (ack && os_last) begin
                    os_done_n = 1'b1;
                    if (!last) ferr_n = 1'b1;
                end
                if (adv && last) begin
                    os_done_n = 1'b0;
                    prst_n    = is_os && (typ_now == 2'd2);
                    wcnt_n    = 4'd0;
                    if (gen_chg) begin
                        state_n = IDLE;
                        bcnt_n  = 4'd0;
                    end else if (bcnt == blk_last) begin
                        state_n = STALL;
                        bcnt_n  = 4'd0;
                    end else begin
                        state_n = is_os ? BLK_OS : BLK_DATA;
                        bcnt_n  = bcnt + 4'd1;
                    end
                end else if (adv) begin
                    wcnt_n  = wcnt + 4'd1;
                    state_n = is_os ? BLK_OS : BLK_DATA;
                end
            end
        end else begin
            wcnt_n    = 4'd0;
            bcnt_n    = 4'd0;
            os_done_n = 1'b0;
            if (state == BLK_OS || grant_os) begin
                ack = os_req;
                if (os_req) begin
                    data_n     = os_data;
                    k_n        = os_k;
                    turn_off_n = 1'b1;
                    prst_n     = os_k[0] && (os_data[7:0] == 8'hBC);
                end
                state_n = (os_req && os_last) ? (gen_chg ? IDLE : BLK_DATA) : BLK_OS;
            end else begin
                rdy     = dl_valid;
                data_n  = dl_valid ? dl_data : '0;
                state_n = gen_chg ? IDLE : BLK_DATA;
            end
        end
    end

    assign os_ack   = ack & reset_n;
    assign dl_ready = rdy & reset_n;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wcnt           <= '0;
            bcnt           <= '0;
            gen_cur        <= '0;
            cur_type       <= '0;
            os_done        <= 1'b0;
            tx_data        <= '0;
            tx_k           <= '0;
            tx_data_valid  <= 1'b0;
            tx_sync_header <= 2'b00;
            tx_start_block <= 1'b0;
            tx_turn_off    <= 1'b0;
            pattern_reset  <= 1'b0;
            frame_err      <= 1'b0;
        end else begin
            state          <= state_n;
            wcnt           <= wcnt_n;
            bcnt           <= bcnt_n;
            if (state == IDLE) gen_cur <= GEN;
            cur_type       <= cur_type_n;
            os_done        <= os_done_n;
            tx_data        <= data_n;
            tx_k           <= k_n;
            tx_data_valid  <= valid_n;
            tx_sync_header <= sync_n;
            tx_start_block <= start_n;
            tx_turn_off    <= turn_off_n;
            pattern_reset  <= prst_n;
            frame_err      <= ferr_n;
        end
    end
endmodule

// File: tb/tb_tx_block_sched.sv
// tb/tb_tx_block_sched.sv - directed self-checking bench for tx_block_sched
module tb_tx_block_sched;
    logic        pclk = 1'b0;
    logic        reset_n;
    logic [2:0]  GEN;
    logic [5:0]  PIPEWIDTH;
    logic        os_req, os_last, os_ack, dl_valid, dl_ready;
    logic [1:0]  os_type;
    logic [31:0] os_data, dl_data, tx_data;
    logic [3:0]  os_k, tx_k;
    logic        tx_data_valid, tx_start_block, tx_turn_off, pattern_reset, frame_err;
    logic [1:0]  tx_sync_header;
    int          checks = 0;
    int          failures = 0;

    tx_block_sched #(.DW(32), .OS_PRIO(1'b1)) dut (
        .pclk(pclk), .reset_n(reset_n), .GEN(GEN), .PIPEWIDTH(PIPEWIDTH),
        .os_req(os_req), .os_type(os_type), .os_data(os_data), .os_k(os_k),
        .os_last(os_last), .os_ack(os_ack), .dl_valid(dl_valid), .dl_data(dl_data),
        .dl_ready(dl_ready), .tx_data(tx_data), .tx_k(tx_k), .tx_data_valid(tx_data_valid),
        .tx_sync_header(tx_sync_header), .tx_start_block(tx_start_block),
        .tx_turn_off(tx_turn_off), .pattern_reset(pattern_reset), .frame_err(frame_err)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic reset_to(input logic [2:0] g, input logic [5:0] pw);
        reset_n = 1'b0; GEN = g; PIPEWIDTH = pw;
        os_req = 1'b0; os_last = 1'b0; os_type = 2'd0; os_data = '0; os_k = '0;
        dl_valid = 1'b0; dl_data = '0;
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_to(3'd3, 6'd32);
        reset_n = 1'b0; os_req = 1'b1; dl_valid = 1'b1;
        cyc();
        chk("rst_data", tx_data, 32'd0);
        chk("rst_valid", 32'(tx_data_valid), 32'd0);
        chk("rst_sync", 32'(tx_sync_header), 32'd0);
        chk("rst_misc", 32'({tx_k, tx_start_block, tx_turn_off, pattern_reset, frame_err}), 32'd0);
        chk("rst_ack", 32'({os_ack, dl_ready}), 32'd0);
        os_req = 1'b0;
        reset_n = 1'b1;

        // Gen3 x32: 16 data blocks of 4 words, then one stall cycle
        for (int i = 0; i < 66; i++) begin
            int w;
            dl_valid = 1'b1; dl_data = 32'hA000_0000 + i;
            #1 chk("t1_ready", 32'(dl_ready), 32'(i != 64));
            cyc();
            chk("t1_valid", 32'(tx_data_valid), 32'(i != 64));
            if (i != 64) begin
                w = (i < 64) ? i % 4 : (i - 65) % 4;
                chk("t1_sync", 32'(tx_sync_header), 32'd1);
                chk("t1_start", 32'(tx_start_block), 32'(w == 0));
                chk("t1_data", tx_data, 32'hA000_0000 + i);
            end
        end

        // Gen3 x8: one EIEOS block, then IDL blocks; stall after the 4th block
        reset_to(3'd3, 6'd8);
        for (int i = 0; i < 66; i++) begin
            os_req = (i < 16); os_type = 2'd2; os_last = (i == 15);
            os_data = 32'hB000_0000 + i;
            #1 chk("t2_ack", 32'(os_ack), 32'(i < 16));
            cyc();
            chk("t2_valid", 32'(tx_data_valid), 32'(i != 64));
            chk("t2_prst", 32'(pattern_reset), 32'(i == 15));
            if (i != 64) begin
                chk("t2_sync", 32'(tx_sync_header), (i < 16) ? 32'd2 : 32'd1);
                chk("t2_data", tx_data, (i < 16) ? 32'hB000_0000 + i : 32'd0);
            end
        end

        // Gen3 x16: both requesters rise at word 3; OS waits for the next word 0
        reset_to(3'd3, 6'd16);
        for (int i = 0; i < 17; i++) begin
            logic ea, er;
            os_req = (i >= 3 && i <= 15); os_last = (i == 15); os_type = 2'd0;
            dl_valid = (i >= 3);
            os_data = 32'hC000_0000 + i; dl_data = 32'hD000_0000 + i;
            ea = (i >= 8 && i <= 15);
            er = (i >= 3 && i <= 7) || (i == 16);
            #1 chk("t3_ack", 32'(os_ack), 32'(ea));
            chk("t3_ready", 32'(dl_ready), 32'(er));
            cyc();
            chk("t3_sync", 32'(tx_sync_header), ea ? 32'd2 : 32'd1);
            chk("t3_start", 32'(tx_start_block), 32'(i == 0 || i == 8 || i == 16));
            chk("t3_data", tx_data, ea ? 32'hC000_0000 + i : (er ? 32'hD000_0000 + i : 32'd0));
        end

        // Gen3 x32: os_last on word 2 of 4 sets sticky frame_err, block ends at word 3
        reset_to(3'd3, 6'd32);
        for (int i = 0; i < 7; i++) begin
            os_req = (i < 3); os_last = (i == 2); os_type = 2'd0;
            dl_valid = (i >= 3);
            os_data = 32'hE000_0000 + i; dl_data = 32'hF000_0000 + i;
            #1 chk("t4_ack", 32'(os_ack), 32'(i < 3));
            chk("t4_ready", 32'(dl_ready), 32'(i >= 4));
            cyc();
            chk("t4_ferr", 32'(frame_err), 32'(i >= 2));
            chk("t4_sync", 32'(tx_sync_header), (i < 4) ? 32'd2 : 32'd1);
            chk("t4_start", 32'(tx_start_block), 32'(i == 0 || i == 4));
            chk("t4_data", tx_data, (i < 3) ? 32'hE000_0000 + i : ((i >= 4) ? 32'hF000_0000 + i : 32'd0));
        end

        // Gen1 x8: SKP ordered set (COM,SKP,SKP,SKP) interrupts data
        reset_to(3'd1, 6'd8);
        for (int i = 0; i < 8; i++) begin
            logic os;
            os = (i >= 2 && i <= 5);
            dl_valid = 1'b1; dl_data = 32'h0000_0040 + i;
            os_req = os; os_last = (i == 5); os_type = 2'd1;
            os_data = os ? ((i == 2) ? 32'h0000_00BC : 32'h0000_001C) : 32'd0;
            os_k = os ? 4'b0001 : 4'b0000;
            #1 chk("t5_ack", 32'(os_ack), 32'(os));
            chk("t5_ready", 32'(dl_ready), 32'(!os));
            cyc();
            chk("t5_turnoff", 32'(tx_turn_off), 32'(os));
            chk("t5_prst", 32'(pattern_reset), 32'(i == 2));
            chk("t5_valid", 32'(tx_data_valid), 32'd1);
            chk("t5_sync", 32'(tx_sync_header), 32'd0);
            chk("t5_k", 32'(tx_k), os ? 32'd1 : 32'd0);
            chk("t5_data", tx_data, os ? ((i == 2) ? 32'h0000_00BC : 32'h0000_001C) : 32'h0000_0040 + i);
        end

        // Gen3 x32: reset asserted at word 2 of an OS block
        reset_to(3'd3, 6'd32);
        os_req = 1'b1; os_type = 2'd1; os_k = 4'b0000; os_last = 1'b0; dl_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            os_data = 32'h5500_0000 + i;
            cyc();
        end
        os_data = 32'h5500_0002;
        #1 chk("t6_ack_mid", 32'(os_ack), 32'd1);
        reset_n = 1'b0;
        #1 chk("t6_valid", 32'(tx_data_valid), 32'd0);
        chk("t6_sync", 32'(tx_sync_header), 32'd0);
        chk("t6_data", tx_data, 32'd0);
        chk("t6_ack_rst", 32'(os_ack), 32'd0);
        cyc();
        reset_n = 1'b1;
        os_data = 32'h6600_0000;
        #1 chk("t6_ack_rel", 32'(os_ack), 32'd1);
        cyc();
        chk("t6_start", 32'(tx_start_block), 32'd1);
        chk("t6_sync_rel", 32'(tx_sync_header), 32'd2);
        chk("t6_data_rel", tx_data, 32'h6600_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
